// File: rtl/pipe_cla_add.sv
// pipe_cla_add: pipelined carry-lookahead adder/subtractor.
//
// Operands are cut into 16-bit groups. Group k is resolved by a 4x4-bit
// two-level CLA in pipeline stage k, which takes the registered carry of
// stage k-1. Higher operand slices ride along in skew registers until their
// stage, and finished low result slices ride along to the output, so all
// slices of one operation leave the last stage together. All stages shift
// together on a single advance enable; a stalled output freezes the pipe.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready = advance enable)
//   a, b, c_in, sub       operands; sub=1 computes a-b and ignores c_in
//   out_valid / out_ready result handshake
//   f, c_out, ovf         result, carry out of MSB, signed overflow
//   gm, pm                whole-word generate/propagate of a and (inverted) b
module pipe_cla_add #(
    parameter int WIDTH = 64,
    parameter int GRP   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             c_out,
    output logic             ovf,
    output logic             gm,
    output logic             pm
);
    localparam int N = WIDTH / GRP;

    // 16-bit two-level CLA. Returns {P_group, G_group, carry_out, sum[15:0]}.
    function automatic logic [18:0] cla16(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci);
        logic [15:0] g, p, c;
        logic [3:0]  gn, pn, gg, pp;
        logic [4:0]  cn;
        logic        cc, g_grp;
        g = x & y;
        p = x ^ y;
        for (int j = 0; j < 4; j++) begin
            gg    = g[4*j +: 4];
            pp    = p[4*j +: 4];
            gn[j] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                  | (pp[3] & pp[2] & pp[1] & gg[0]);
            pn[j] = &pp;
        end
        g_grp = gn[3] | (pn[3] & gn[2]) | (pn[3] & pn[2] & gn[1])
              | (pn[3] & pn[2] & pn[1] & gn[0]);
        cn[0] = ci;
        cn[1] = gn[0] | (pn[0] & ci);
        cn[2] = gn[1] | (pn[1] & gn[0]) | (pn[1] & pn[0] & ci);
        cn[3] = gn[2] | (pn[2] & gn[1]) | (pn[2] & pn[1] & gn[0])
              | (pn[2] & pn[1] & pn[0] & ci);
        cn[4] = g_grp | ((&pn) & ci);
        for (int j = 0; j < 4; j++) begin
            gg         = g[4*j +: 4];
            pp         = p[4*j +: 4];
            cc         = cn[j];
            c[4*j]     = cc;
            c[4*j + 1] = gg[0] | (pp[0] & cc);
            c[4*j + 2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cc);
            c[4*j + 3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                       | (pp[2] & pp[1] & pp[0] & cc);
        end
        return {&pn, g_grp, cn[4], p ^ c};
    endfunction

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Stage registers (stage N-1 is the output register).
    logic [N-1:0]     v_reg, c_reg, g_reg, p_reg;
    logic [WIDTH-1:0] a_reg [N];
    logic [WIDTH-1:0] b_reg [N];
    logic [WIDTH-1:0] f_reg [N];
    logic             ovf_reg;

    // What stage k consumes, and what it produces.
    logic [N-1:0]     v_src, c_src, g_src, p_src;
    logic [WIDTH-1:0] a_src [N];
    logic [WIDTH-1:0] b_src [N];
    logic [WIDTH-1:0] f_src [N];
    logic [WIDTH-1:0] f_next [N];
    logic [N-1:0]     c_next, g_next, p_next;
    logic             ovf_next;

    assign adv      = !v_reg[N-1] || out_ready;
    assign in_ready = adv;
    assign b_eff    = sub ? ~b : b;
    assign cin_eff  = sub ? 1'b1 : c_in;

    for (genvar gi = 0; gi < N; gi++) begin : g_stage
        logic [18:0] res;
        if (gi == 0) begin : g_src_in
            assign v_src[0] = in_valid;
            assign a_src[0] = a;
            assign b_src[0] = b_eff;
            assign f_src[0] = '0;
            assign c_src[0] = cin_eff;
            // Identity element of the generate/propagate combine.
            assign g_src[0] = 1'b0;
            assign p_src[0] = 1'b1;
        end else begin : g_src_prev
            assign v_src[gi] = v_reg[gi-1];
            assign a_src[gi] = a_reg[gi-1];
            assign b_src[gi] = b_reg[gi-1];
            assign f_src[gi] = f_reg[gi-1];
            assign c_src[gi] = c_reg[gi-1];
            assign g_src[gi] = g_reg[gi-1];
            assign p_src[gi] = p_reg[gi-1];
        end
        assign res = cla16(a_src[gi][gi*GRP +: GRP], b_src[gi][gi*GRP +: GRP], c_src[gi]);
        // Result bits above the groups done so far are always zero, so OR-ing
        // the new slice in is enough.
        assign f_next[gi] = f_src[gi] | (WIDTH'(res[15:0]) << (gi*GRP));
        assign c_next[gi] = res[16];
        assign g_next[gi] = res[17] | (res[18] & g_src[gi]);
        assign p_next[gi] = res[18] & p_src[gi];
    end

    // Carry into the MSB is recovered from the MSB sum bit.
    assign ovf_next = a_src[N-1][WIDTH-1] ^ b_src[N-1][WIDTH-1]
                    ^ f_next[N-1][WIDTH-1] ^ c_next[N-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_reg   <= '0;
            c_reg   <= '0;
            g_reg   <= '0;
            p_reg   <= '0;
            ovf_reg <= 1'b0;
            for (int k = 0; k < N; k++) begin
                a_reg[k] <= '0;
                b_reg[k] <= '0;
                f_reg[k] <= '0;
            end
        end else if (adv) begin
            v_reg <= v_src;
            // Data only loads behind a valid beat, so bubbles never disturb
            // the held output values.
            for (int k = 0; k < N; k++) begin
                if (v_src[k]) begin
                    a_reg[k] <= a_src[k];
                    b_reg[k] <= b_src[k];
                    f_reg[k] <= f_next[k];
                    c_reg[k] <= c_next[k];
                    g_reg[k] <= g_next[k];
                    p_reg[k] <= p_next[k];
                end
            end
            if (v_src[N-1]) begin
                ovf_reg <= ovf_next;
            end
        end
    end

    assign out_valid = v_reg[N-1];
    assign f         = f_reg[N-1];
    assign c_out     = c_reg[N-1];
    assign ovf       = ovf_reg;
    assign gm        = g_reg[N-1];
    assign pm        = p_reg[N-1];

endmodule
